// File: rtl/branch_predictor_pkg.sv
// Shared encodings and helpers for the 2-bit saturating branch history table.
package branch_predictor_pkg;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    localparam int DEFAULT_IDX_BITS = 6;
    localparam int CNT_W            = 32;

    // The upper counter bit is the taken/not-taken prediction.
    function automatic logic bht_taken(input logic [1:0] state);
        return state[1];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/branch_predictor_sat2.sv
// Next-state function for one 2-bit saturating counter; clamps at both ends.
module bp_sat2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next
);

    always_comb begin
        next = cnt;
        if (taken) begin
            if (cnt != BHT_ST) begin
                next = cnt + 2'd1;
            end
        end else begin
            if (cnt != BHT_SNT) begin
                next = cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Untagged BHT of 2-bit counters: zero-latency fetch prediction, decode-stage
// resolution and mispredict flagging, plus saturating branch statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_BITS   = DEFAULT_IDX_BITS,
    parameter logic [1:0] INIT_STATE = BHT_WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic [31:0] pcD,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branchD,
    input  logic        actual_takenD,
    output logic        predict_takenF,
    output logic        predict_takenD,
    output logic        mispredictD,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int DEPTH = 2 ** IDX_BITS;

    // Flop array rather than RAM so that reset clears every entry in one cycle.
    logic [1:0]          bht_reg [DEPTH];
    logic [IDX_BITS-1:0] idx_f;
    logic [IDX_BITS-1:0] idx_d;
    logic [1:0]          bht_next;
    logic [DEPTH-1:0]    wr_en;
    logic                upd;
    logic                predict_taken_d_reg;
    logic [CNT_W-1:0]    branch_cnt_reg;
    logic [CNT_W-1:0]    mispred_cnt_reg;
    logic                unused_pc_bits;

    assign idx_f = pcF[IDX_BITS+1:2];
    assign idx_d = pcD[IDX_BITS+1:2];
    assign unused_pc_bits = ^{pcF[31:IDX_BITS+2], pcF[1:0], pcD[31:IDX_BITS+2], pcD[1:0]};

    assign upd = branchD & ~stallD & ~flushD;

    // No bypass: a same-index update this cycle is only visible next cycle.
    assign predict_takenF = bht_taken(bht_reg[idx_f]);

    bp_sat2 u_sat2 (
        .cnt   (bht_reg[idx_d]),
        .taken (actual_takenD),
        .next  (bht_next)
    );

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = upd && (idx_d == IDX_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bht_reg[i] <= INIT_STATE;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en[i]) begin
                    bht_reg[i] <= bht_next;
                end
            end
        end
    end

    // Prediction follows its instruction into decode; flush beats stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            predict_taken_d_reg <= 1'b0;
        end else if (flushD) begin
            predict_taken_d_reg <= 1'b0;
        end else if (!stallD) begin
            predict_taken_d_reg <= predict_takenF;
        end
    end

    assign predict_takenD = predict_taken_d_reg;
    assign mispredictD    = branchD & (predict_taken_d_reg != actual_takenD);

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_reg  <= '0;
            mispred_cnt_reg <= '0;
        end else if (upd) begin
            branch_cnt_reg <= sat_inc(branch_cnt_reg);
            if (mispredictD) begin
                mispred_cnt_reg <= sat_inc(mispred_cnt_reg);
            end
        end
    end

    assign branch_cnt  = branch_cnt_reg;
    assign mispred_cnt = mispred_cnt_reg;

endmodule
